// File: rtl/gen_burst_ctrl.sv
// Burst sequencer between the counter data generator and the FIFO write port.
// Emits num_bursts bursts of burst_len words separated by gap_cycles idle cycles.
module gen_burst_ctrl #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int NB_W   = 8,
    parameter int GAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [NB_W-1:0]   num_bursts,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic [DATA_W-1:0] ge_data,
    input  logic              ge_valid,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy,
    output logic              done,
    output logic [31:0]       word_cnt,
    output logic [15:0]       drop_cnt
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | config latched, check for empty sequence
    // RUN   | passing generator beats to the FIFO
    // GAP   | idle cycles between bursts
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state, next_state;
    logic [LEN_W-1:0]   cfg_len;
    logic [NB_W-1:0]    cfg_nb;
    logic [GAP_W-1:0]   cfg_gap;
    logic [LEN_W-1:0]   beat_cnt;
    logic [NB_W-1:0]    burst_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic accept;
    logic beat;
    logic drop;
    logic last_beat;
    logic last_burst;

    always_comb begin
        next_state = state;
        accept     = (state == IDLE) && start && !abort;
        beat       = (state == RUN) && !abort && ge_valid && !fifo_full;
        drop       = (state == RUN) && !abort && ge_valid && fifo_full;
        last_beat  = beat && ((beat_cnt + LEN_W'(1)) == cfg_len);
        last_burst = (burst_cnt + NB_W'(1)) == cfg_nb;

        case (state)
            IDLE: if (accept) next_state = LOAD;
            LOAD: begin
                if (abort)                             next_state = IDLE;
                else if (cfg_nb == '0 || cfg_len == '0) next_state = DONE;
                else                                   next_state = RUN;
            end
            RUN: begin
                if (abort) next_state = IDLE;
                else if (last_beat) begin
                    if (last_burst)          next_state = DONE;
                    else if (cfg_gap == '0)  next_state = RUN;
                    else                     next_state = GAP;
                end
            end
            GAP: begin
                if (abort)                        next_state = IDLE;
                else if (gap_cnt == GAP_W'(1))    next_state = RUN;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            cfg_len    <= '0;
            cfg_nb     <= '0;
            cfg_gap    <= '0;
            beat_cnt   <= '0;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            word_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= next_state;
            busy       <= (next_state == LOAD) || (next_state == RUN) || (next_state == GAP);
            done       <= (next_state == DONE);
            fifo_wr_en <= beat;

            if (beat) fifo_din <= ge_data;

            if (accept) begin
                cfg_len   <= burst_len;
                cfg_nb    <= num_bursts;
                cfg_gap   <= gap_cycles;
                beat_cnt  <= '0;
                burst_cnt <= '0;
                word_cnt  <= '0;
                drop_cnt  <= '0;
            end

            if (beat) begin
                word_cnt <= word_cnt + 32'd1;
                if (last_beat) begin
                    beat_cnt  <= '0;
                    burst_cnt <= burst_cnt + NB_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + LEN_W'(1);
                end
            end

            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

            // gap timer: loaded on burst end, terminal count at 1
            if (state == RUN && next_state == GAP)  gap_cnt <= cfg_gap;
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_gen_burst_ctrl.sv
// Directed bench for gen_burst_ctrl: burst shape, backpressure drops, empty
// sequences, abort, async reset, ignored restart and generator wrap.
module tb_gen_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] burst_len;
    logic [7:0]  num_bursts, gap_cycles;
    logic [31:0] ge_data;
    logic        ge_valid, fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        busy, done;
    logic [31:0] word_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    gen_burst_ctrl #(.DATA_W(32), .LEN_W(16), .NB_W(8), .GAP_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .burst_len  (burst_len),
        .num_bursts (num_bursts),
        .gap_cycles (gap_cycles),
        .ge_data    (ge_data),
        .ge_valid   (ge_valid),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt),
        .drop_cnt   (drop_cnt)
    );

    // free-running generator: value advances every clock
    logic [31:0] cyc_cnt = 32'd0;
    logic [31:0] gen_base = 32'd0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;
    assign ge_data = cyc_cnt + gen_base;

    logic [31:0] wq[$];
    int          wc[$];
    int          done_seen = 0;
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wq.push_back(fifo_din);
            wc.push_back(int'(cyc_cnt));
        end
        if (done) done_seen++;
    end

    int total = 0;
    int bad   = 0;
    int wbase = 0;
    int dbase = 0;

    logic [31:0] exp1 [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd7, 32'd8, 32'd9, 32'd10};
    logic [31:0] exp2 [8] = '{32'd0, 32'd1, 32'd2, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // called on a falling edge; returns one cycle later with the sequence in LOAD
    task automatic begin_seq(input logic [15:0] len, input logic [7:0] nb,
                             input logic [7:0] gap, input logic [31:0] first);
        burst_len  = len;
        num_bursts = nb;
        gap_cycles = gap;
        start      = 1'b1;
        gen_base   = (first - 32'd2) - cyc_cnt;
        wbase      = wq.size();
        dbase      = done_seen;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1);
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        burst_len = '0; num_bursts = '0; gap_cycles = '0;
        ge_valid = 1'b1; fifo_full = 1'b0;
        #12;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din",   fifo_din,   0);
        chk("rst_busy",  busy,       0);
        chk("rst_done",  done,       0);
        chk("rst_words", word_cnt,   0);
        chk("rst_drops", drop_cnt,   0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // start together with abort is refused
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        tick(1);

        // 1: two bursts of four with a three-cycle gap
        begin_seq(16'd4, 8'd2, 8'd3, 32'd0);
        wait_done("t1_done_timeout");
        chk("t1_count", wq.size() - wbase, 8);
        for (int i = 0; i < 8 && wbase + i < wq.size(); i++)
            chk($sformatf("t1_data%0d", i), wq[wbase+i], exp1[i]);
        if (wq.size() - wbase >= 5)
            chk("t1_gap_cycles", wc[wbase+4] - wc[wbase+3], 4);
        chk("t1_word_cnt", word_cnt, 8);
        chk("t1_drop_cnt", drop_cnt, 0);
        chk("t1_done_once", done_seen - dbase, 1);
        chk("t1_busy_end", busy, 0);

        // 2: backpressure for three cycles mid-burst
        begin_seq(16'd8, 8'd1, 8'd0, 32'd0);
        tick(4);
        fifo_full = 1'b1;
        tick(3);
        fifo_full = 1'b0;
        wait_done("t2_done_timeout");
        chk("t2_count", wq.size() - wbase, 8);
        for (int i = 0; i < 8 && wbase + i < wq.size(); i++)
            chk($sformatf("t2_data%0d", i), wq[wbase+i], exp2[i]);
        chk("t2_drop_cnt", drop_cnt, 3);
        chk("t2_word_cnt", word_cnt, 8);

        // 3: empty sequences complete through LOAD only
        begin_seq(16'd5, 8'd0, 8'd2, 32'd0);
        chk("t3a_busy_load", busy, 1);
        chk("t3a_done_early", done, 0);
        tick(1);
        chk("t3a_done", done, 1);
        chk("t3a_busy_done", busy, 0);
        tick(1);
        chk("t3a_done_once", done, 0);
        chk("t3a_no_writes", wq.size() - wbase, 0);
        begin_seq(16'd0, 8'd3, 8'd0, 32'd0);
        tick(1);
        chk("t3b_done", done, 1);
        tick(2);
        chk("t3b_no_writes", wq.size() - wbase, 0);
        chk("t3b_word_cnt", word_cnt, 0);

        // 4: abort after five writes, then a clean restart
        begin_seq(16'd10, 8'd1, 8'd0, 32'd0);
        tick(6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4_busy_after_abort", busy, 0);
        chk("t4_wr_after_abort", fifo_wr_en, 0);
        tick(2);
        chk("t4_word_cnt", word_cnt, 5);
        chk("t4_count", wq.size() - wbase, 5);
        chk("t4_no_done", done_seen - dbase, 0);
        if (wq.size() - wbase >= 5)
            chk("t4_last_data", wq[wbase+4], 4);
        begin_seq(16'd3, 8'd1, 8'd0, 32'h100);
        chk("t4_restart_cleared", word_cnt, 0);
        wait_done("t4_restart_timeout");
        chk("t4_restart_words", word_cnt, 3);
        if (wq.size() > wbase)
            chk("t4_restart_data", wq[wbase], 32'h100);

        // 5a: start while busy is ignored
        begin_seq(16'd6, 8'd1, 8'd0, 32'h200);
        tick(2);
        burst_len = 16'd2; num_bursts = 8'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("t5a_done_timeout");
        chk("t5a_word_cnt", word_cnt, 6);
        chk("t5a_count", wq.size() - wbase, 6);

        // 5b: asynchronous reset mid-burst
        begin_seq(16'd20, 8'd1, 8'd0, 32'h300);
        tick(5);
        chk("t5b_pre_wr", fifo_wr_en, 1);
        chk("t5b_pre_words", word_cnt, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5b_rst_wr", fifo_wr_en, 0);
        chk("t5b_rst_din", fifo_din, 0);
        chk("t5b_rst_busy", busy, 0);
        chk("t5b_rst_words", word_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wbase = wq.size();
        tick(3);
        chk("t5b_idle_after", busy, 0);
        chk("t5b_no_writes", wq.size() - wbase, 0);

        // 6: generator wrap across two back-to-back bursts
        begin_seq(16'd5, 8'd2, 8'd0, 32'hFFFF_FFFD);
        wait_done("t6_done_timeout");
        chk("t6_count", wq.size() - wbase, 10);
        for (int i = 0; i < 10 && wbase + i < wq.size(); i++) begin
            logic [31:0] e;
            e = 32'hFFFF_FFFD + 32'(i);
            chk($sformatf("t6_data%0d", i), wq[wbase+i], e);
        end
        if (wq.size() - wbase >= 10)
            chk("t6_back_to_back", wc[wbase+9] - wc[wbase], 9);
        chk("t6_word_cnt", word_cnt, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
